comp_chain_seq: RTL and testbench
=================================

Name: comp_chain_seq

Overview:
Sequential wide-operand comparator back-end that sits directly downstream of the 2-bit magnitude comparator COMP2. It consumes one COMP2 result triple (E, G, L) per accepted chunk, MSB chunk first, across NCHUNK chunks. It produces the equal/greater/less verdict for the full 2*NCHUNK-bit operands. A valid/ready handshake throttles the chunk stream, and non-one-hot input triples are flagged.

Parameters:
NCHUNK, 4, number of 2-bit chunks per comparison (operand width = 2*NCHUNK); legal range 1..64
CW, $clog2(NCHUNK) with minimum 1, chunk counter width (derived, not overridden)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset, sampled on rising edge of clk
start  input  1  begin new comparison; sampled only in IDLE
abort  input  1  synchronous abort; returns to IDLE from any state
in_valid  input  1  E/G/L triple presented for current chunk
in_ready  output  1  block accepts a chunk this cycle
E  input  1  COMP2 equal flag for current chunk
G  input  1  COMP2 greater flag for current chunk
L  input  1  COMP2 less flag for current chunk
busy  output  1  high in ACCUM and DONE
done  output  1  one-cycle pulse: result valid
eq_o  output  1  full operands equal
gt_o  output  1  operand a greater than b
lt_o  output  1  operand a less than b
err  output  1  at least one accepted triple was not one-hot
chunk_idx  output  CW  index of the next chunk to accept (0 = MSB chunk)

Behaviour:
- Reset (rst_n=0 at edge): state IDLE; in_ready, busy, done, eq_o, gt_o, lt_o, err = 0; chunk_idx = 0; internal decided flag = 0. Reset has priority over abort, start and in_valid.
- Accept event: in_valid & in_ready at a rising edge.
- IDLE:
  - in_ready=0 and busy=0.
  - If start=1 (and abort=0): go to ACCUM; clear chunk_idx, decided, eq_o/gt_o/lt_o and err.
  - Results from the previous operation stay held until that start.
- ACCUM:
  - in_ready=1 (combinational from state, no dependence on in_valid).
  - On accept with a one-hot triple and decided=0:
    - G=1: set decided, record gt.
    - L=1: set decided, record lt.
    - E=1: no change.
  - Once decided=1, later triples do not alter the verdict (MSB-first priority). They are still consumed and still checked for one-hot.
  - Non-one-hot triple (000, 011, 101, 110, 111): set sticky err. The chunk counts toward NCHUNK and does not affect the verdict.
  - chunk_idx increments on each accept. When the accepted chunk has chunk_idx = NCHUNK-1, go to DONE; chunk_idx wraps to 0.
  - start in ACCUM is ignored.
- DONE, exactly one cycle:
  - done=1, in_ready=0, busy=1.
  - Outputs registered on entry:
    - err=0: gt_o / lt_o = recorded verdict; eq_o = ~decided. Exactly one of the three is high.
    - err=1: eq_o = gt_o = lt_o = 0.
  - Next state is IDLE unconditionally; a start in DONE is ignored.
- Latency: done rises on the clock edge that accepts the last chunk (visible the following cycle). Minimum operation is NCHUNK+2 cycles from start sampled to IDLE with in_valid held high.
- abort=1 at an edge in ACCUM or DONE: go to IDLE. Clear chunk_idx, decided, eq_o, gt_o, lt_o and err. No done pulse. Any chunk presented that cycle is not accepted.
- Reset mid-operation: identical to power-on reset; no done pulse.
- NCHUNK=1: first accept goes straight to DONE.
- Input stalls: in_valid=0 in ACCUM holds all state; no timeout.

Test Plan:
1. NCHUNK=4, a=8'hB4 vs b=8'hB1: chunk triples E,G,L = 100, 100, 010, 001, in_valid held high -> done pulses once 5 cycles after start; gt_o=1, eq_o=0, lt_o=0, err=0; later L chunk ignored.
2. a=8'h3C vs b=8'h3C (all triples 100) -> done with eq_o=1, gt_o=lt_o=0; then a second run with first triple 001 -> lt_o=1, and previous eq_o clears on start.
3. Stall: in_valid toggling 1,0,0,1,0,1,1 over four chunks -> chunk_idx advances only on accepts; done one cycle after the 4th accept; in_ready stays 1 throughout ACCUM.
4. Error: second triple 011 among 100,011,010,100 -> done with err=1 and eq_o=gt_o=lt_o=0; next start clears err.
5. abort asserted after 2 accepts -> IDLE next cycle; busy=0, no done, chunk_idx=0, results 0. rst_n=0 after 3 accepts -> same, and start during that reset cycle ignored.
6. NCHUNK=1: start then single triple 010 -> done 1 cycle after accept with gt_o=1. start held high in ACCUM and DONE does not restart; a new op begins only on start sampled in IDLE.

Source files
------------

// File: rtl/comp_chain_seq_if.sv
// Chunk stream from COMP2: one E/G/L triple per beat under valid/ready.
interface comp_chain_seq_if;
  logic in_valid;
  logic in_ready;
  logic E;
  logic G;
  logic L;

  modport master (output in_valid, output E, output G, output L, input in_ready);
  modport slave  (input in_valid, input E, input G, input L, output in_ready);
endinterface

// File: rtl/comp_chain_seq.sv
// Sequential MSB-first comparator back-end: folds NCHUNK COMP2 triples into
// one eq/gt/lt verdict and flags any triple that is not one-hot.
module comp_chain_seq #(
  parameter int NCHUNK = 4,
  localparam int CW = (NCHUNK > 1) ? $clog2(NCHUNK) : 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   start,
  input  logic                   abort,
  comp_chain_seq_if.slave        chunk,
  output logic                   busy,
  output logic                   done,
  output logic                   eq_o,
  output logic                   gt_o,
  output logic                   lt_o,
  output logic                   err,
  output logic [CW-1:0]          chunk_idx,
  output logic [1:0]             state_dbg
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ACCUM = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  // Handshake: a chunk is consumed on a rising edge where in_valid and
  // in_ready are both high; in_ready depends on state only, never on in_valid.

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] idx_q, idx_d;
  logic          decided_q, decided_d;
  logic          rec_gt_q, rec_gt_d;
  logic          err_q, err_d;
  logic          eq_q, eq_d;
  logic          gt_q, gt_d;
  logic          lt_q, lt_d;

  logic [2:0] egl;
  logic       one_hot;
  logic       accept;

  assign egl     = {chunk.E, chunk.G, chunk.L};
  assign one_hot = (egl == 3'b100) || (egl == 3'b010) || (egl == 3'b001);
  assign accept  = chunk.in_valid && (state_q == ST_ACCUM);

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    decided_d = decided_q;
    rec_gt_d  = rec_gt_q;
    err_d     = err_q;
    eq_d      = eq_q;
    gt_d      = gt_q;
    lt_d      = lt_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d   = ST_ACCUM;
          idx_d     = '0;
          decided_d = 1'b0;
          rec_gt_d  = 1'b0;
          err_d     = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end
      ST_ACCUM: begin
        if (abort) begin
          state_d   = ST_IDLE;
          idx_d     = '0;
          decided_d = 1'b0;
          rec_gt_d  = 1'b0;
          err_d     = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end else if (accept) begin
          // First decisive chunk wins; later chunks are only checked for one-hot.
          if (!one_hot) begin
            err_d = 1'b1;
          end else if (!decided_q && chunk.G) begin
            decided_d = 1'b1;
            rec_gt_d  = 1'b1;
          end else if (!decided_q && chunk.L) begin
            decided_d = 1'b1;
            rec_gt_d  = 1'b0;
          end
          if (idx_q == CW'(NCHUNK - 1)) begin
            state_d = ST_DONE;
            idx_d   = '0;
            eq_d    = !err_d && !decided_d;
            gt_d    = !err_d && decided_d && rec_gt_d;
            lt_d    = !err_d && decided_d && !rec_gt_d;
          end else begin
            idx_d = idx_q + CW'(1);
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        if (abort) begin
          idx_d     = '0;
          decided_d = 1'b0;
          rec_gt_d  = 1'b0;
          err_d     = 1'b0;
          eq_d      = 1'b0;
          gt_d      = 1'b0;
          lt_d      = 1'b0;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      decided_q <= 1'b0;
      rec_gt_q  <= 1'b0;
      err_q     <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      decided_q <= decided_d;
      rec_gt_q  <= rec_gt_d;
      err_q     <= err_d;
      eq_q      <= eq_d;
      gt_q      <= gt_d;
      lt_q      <= lt_d;
    end
  end

  assign chunk.in_ready = (state_q == ST_ACCUM);
  assign busy           = (state_q == ST_ACCUM) || (state_q == ST_DONE);
  assign done           = (state_q == ST_DONE);
  assign eq_o           = eq_q;
  assign gt_o           = gt_q;
  assign lt_o           = lt_q;
  assign err            = err_q;
  assign chunk_idx      = idx_q;
  assign state_dbg      = state_q;

endmodule

// File: tb/tb_comp_chain_seq.sv
// Directed bench for comp_chain_seq: NCHUNK=4 instance driven from a vector
// table, NCHUNK=1 instance driven by a hand-written sequence.
module tb_comp_chain_seq;

  typedef struct {
    logic       rst_n;
    logic       start;
    logic       abort;
    logic       valid;
    logic [2:0] egl;
    logic [6:0] exp;   // {in_ready, busy, done, eq_o, gt_o, lt_o, err}
    logic [1:0] idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic start0, abort0, start1, abort1;
  logic busy0, done0, eq0, gt0, lt0, err0;
  logic busy1, done1, eq1, gt1, lt1, err1;
  logic [1:0] idx0;
  logic [0:0] idx1;
  logic [1:0] st_dbg0, st_dbg1;

  int tests  = 0;
  int failed = 0;
  logic [3:0] exp_q[$];   // expected {eq, gt, lt, err} per done pulse of dut0
  vec_t tbl[$];

  always #5 clk = ~clk;

  comp_chain_seq_if if0 ();
  comp_chain_seq_if if1 ();

  comp_chain_seq #(.NCHUNK(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start0), .abort(abort0), .chunk(if0),
    .busy(busy0), .done(done0), .eq_o(eq0), .gt_o(gt0), .lt_o(lt0),
    .err(err0), .chunk_idx(idx0), .state_dbg(st_dbg0)
  );

  comp_chain_seq #(.NCHUNK(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort1), .chunk(if1),
    .busy(busy1), .done(done1), .eq_o(eq1), .gt_o(gt1), .lt_o(lt1),
    .err(err1), .chunk_idx(idx1), .state_dbg(st_dbg1)
  );

  function automatic vec_t mk(input logic r, input logic s, input logic a,
                              input logic v, input logic [2:0] egl,
                              input logic [6:0] exp, input logic [1:0] idx);
    vec_t t;
    t.rst_n = r; t.start = s; t.abort = a; t.valid = v;
    t.egl = egl; t.exp = exp; t.idx = idx;
    return t;
  endfunction

  // Every done pulse of dut0 must match the next expected verdict.
  always @(negedge clk) begin
    if (done0 === 1'b1) begin
      tests++;
      if (exp_q.size() == 0) begin
        failed++;
        $display("FAIL done_unexpected: got eq/gt/lt/err=%b, none required", {eq0, gt0, lt0, err0});
      end else begin
        logic [3:0] e;
        e = exp_q.pop_front();
        if ({eq0, gt0, lt0, err0} !== e) begin
          failed++;
          $display("FAIL done_verdict: got eq/gt/lt/err=%b, required %b", {eq0, gt0, lt0, err0}, e);
        end
      end
    end
  end

  task automatic step0(input vec_t v, input int row);
    logic [6:0] act;
    rst_n = v.rst_n; start0 = v.start; abort0 = v.abort;
    if0.in_valid = v.valid; {if0.E, if0.G, if0.L} = v.egl;
    if (v.exp[4] && v.rst_n) exp_q.push_back(v.exp[3:0]);
    @(posedge clk); #1;
    act = {if0.in_ready, busy0, done0, eq0, gt0, lt0, err0};
    tests++;
    if ({act, idx0} !== {v.exp, v.idx}) begin
      failed++;
      $display("FAIL row%0d: got rdy/busy/done/eq/gt/lt/err=%b idx=%0d, required %b idx=%0d",
               row, act, idx0, v.exp, v.idx);
    end
  endtask

  task automatic step1(input vec_t v, input string name);
    logic [6:0] act;
    start1 = v.start; abort1 = v.abort;
    if1.in_valid = v.valid; {if1.E, if1.G, if1.L} = v.egl;
    @(posedge clk); #1;
    act = {if1.in_ready, busy1, done1, eq1, gt1, lt1, err1};
    tests++;
    if ({act, 1'b0, idx1} !== {v.exp, v.idx}) begin
      failed++;
      $display("FAIL %s: got rdy/busy/done/eq/gt/lt/err=%b idx=%0d, required %b idx=%0d",
               name, act, idx1, v.exp, v.idx);
    end
  endtask

  initial begin
    rst_n = 1'b0; start0 = 1'b0; abort0 = 1'b0; start1 = 1'b0; abort1 = 1'b0;
    if0.in_valid = 1'b0; if0.E = 1'b0; if0.G = 1'b0; if0.L = 1'b0;
    if1.in_valid = 1'b0; if1.E = 1'b0; if1.G = 1'b0; if1.L = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if ({if0.in_ready, busy0, done0, eq0, gt0, lt0, err0, idx0} !== 9'd0) begin
      failed++;
      $display("FAIL reset0: got %b, required 0", {if0.in_ready, busy0, done0, eq0, gt0, lt0, err0, idx0});
    end
    tests++;
    if ({if1.in_ready, busy1, done1, eq1, gt1, lt1, err1, idx1} !== 8'd0) begin
      failed++;
      $display("FAIL reset1: got %b, required 0", {if1.in_ready, busy1, done1, eq1, gt1, lt1, err1, idx1});
    end

    // B4 vs B1: third chunk decides gt, fourth (L) is ignored
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 2));
    tbl.push_back(mk(1, 0, 0, 1, 3'b010, 7'b1100000, 3));
    tbl.push_back(mk(1, 0, 0, 1, 3'b001, 7'b0110100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7'b0000100, 0));
    // 3C vs 3C equal, chunk offered in IDLE is not taken, then lt run
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 2));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 3));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b0111000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'b010, 7'b0001000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7'b0001000, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'b001, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 2));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 3));
    tbl.push_back(mk(1, 0, 0, 1, 3'b010, 7'b0110010, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7'b0000010, 0));
    // stalls: in_valid 1,0,0,1,0,1,1
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'b010, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 0, 3'b001, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 2));
    tbl.push_back(mk(1, 0, 0, 0, 3'b001, 7'b1100000, 2));
    tbl.push_back(mk(1, 0, 0, 1, 3'b010, 7'b1100000, 3));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b0110100, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7'b0000100, 0));
    // non-one-hot second chunk
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3'b011, 7'b1100001, 2));
    tbl.push_back(mk(1, 0, 0, 1, 3'b010, 7'b1100001, 3));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b0110001, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7'b0000001, 0));
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0));
    // abort after two accepts (err already set) with a chunk offered
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3'b111, 7'b1100001, 2));
    tbl.push_back(mk(1, 0, 1, 1, 3'b001, 7'b0000000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7'b0000000, 0));
    // reset after three accepts, start during reset ignored
    tbl.push_back(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 1));
    tbl.push_back(mk(1, 0, 0, 1, 3'b100, 7'b1100000, 2));
    tbl.push_back(mk(1, 0, 0, 1, 3'b010, 7'b1100000, 3));
    tbl.push_back(mk(0, 1, 0, 1, 3'b001, 7'b0000000, 0));
    tbl.push_back(mk(1, 0, 0, 0, 3'b000, 7'b0000000, 0));

    for (int i = 0; i < tbl.size(); i++) step0(tbl[i], i);

    // NCHUNK=1: start held high through ACCUM and DONE must not restart
    step1(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0), "n1_start");
    step1(mk(1, 1, 0, 0, 3'b100, 7'b1100000, 0), "n1_stall_start_held");
    step1(mk(1, 1, 0, 1, 3'b010, 7'b0110100, 0), "n1_done_gt");
    step1(mk(1, 1, 0, 0, 3'b000, 7'b0000100, 0), "n1_idle_after_done");
    step1(mk(1, 1, 0, 0, 3'b000, 7'b1100000, 0), "n1_restart");
    step1(mk(1, 0, 0, 1, 3'b100, 7'b0111000, 0), "n1_done_eq");
    step1(mk(1, 0, 0, 0, 3'b000, 7'b0001000, 0), "n1_idle_hold");

    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL done_missing: got %0d verdicts outstanding, required 0", exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
